// File: rtl/hl_pkg.sv
// Shared definitions for the hidden-layer neuron back end.
//   PROD_W / ACC_W / OUT_W : default widths of the product stream, the
//                            accumulator and the unsigned activation.
//   state_t                : accumulator control states.
//   sat_add                : signed add clamped to a w-bit two's complement range.
package hl_pkg;

    localparam int PROD_W = 20;
    localparam int ACC_W  = 27;
    localparam int OUT_W  = 10;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FINISH,
        OUTPUT
    } state_t;

    typedef struct packed {
        logic signed [63:0] sum;
        logic               sat;
    } sat_res_t;

    // Operands arrive sign-extended to 64 bits, so the raw sum cannot wrap for
    // any accumulator narrower than 63 bits; only the clamp to w bits matters.
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int unsigned        w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] s;
        sat_res_t           r;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        s  = a + b;
        if (s > hi) begin
            r.sum = hi;
            r.sat = 1'b1;
        end else if (s < lo) begin
            r.sum = lo;
            r.sat = 1'b1;
        end else begin
            r.sum = s;
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/relu_clip.sv
// Combinational activation stage: ReLU, fixed-point rescale and clip.
//   sum : signed biased dot product (ACC_W bits)
//   act : unsigned activation, 0 for negative sums, otherwise
//         sum >>> FRAC_SHIFT saturated to 2^OUT_W - 1
module relu_clip #(
    parameter int ACC_W      = hl_pkg::ACC_W,
    parameter int OUT_W      = hl_pkg::OUT_W,
    parameter int FRAC_SHIFT = 6
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic        [OUT_W-1:0] act
);

    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << OUT_W) - 1);

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = sum >>> FRAC_SHIFT;
        if (sum < 0) begin
            act = '0;
        end else if (shifted > Y_MAX) begin
            act = '1;
        end else begin
            act = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/neuron_accumulator.sv
// Hidden-layer neuron back end: accumulates one neuron's signed products with
// saturation, adds the bias sampled on the first beat, then applies ReLU,
// scaling and clipping to produce an unsigned activation.
//   clk, rst              : clock, synchronous active-high reset
//   prod_valid/ready      : product stream handshake
//   prod_data, prod_last  : signed product, final beat of this neuron
//   bias                  : neuron bias, taken with the first accepted beat
//   out_valid/ready       : activation handshake
//   out_data              : unsigned activation
//   out_sat               : a clamp occurred in accumulation or bias add
//   out_len_err           : neuron ended at N_INPUTS beats without prod_last
module neuron_accumulator #(
    parameter int PROD_W     = hl_pkg::PROD_W,
    parameter int ACC_W      = hl_pkg::ACC_W,
    parameter int N_INPUTS   = 64,
    parameter int FRAC_SHIFT = 6,
    parameter int OUT_W      = hl_pkg::OUT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prod_valid,
    input  logic signed [PROD_W-1:0] prod_data,
    input  logic                     prod_last,
    output logic                     prod_ready,
    input  logic signed [PROD_W-1:0] bias,
    output logic                     out_valid,
    output logic        [OUT_W-1:0]  out_data,
    output logic                     out_sat,
    output logic                     out_len_err,
    input  logic                     out_ready
);

    import hl_pkg::*;

    localparam int CNT_W = $clog2(N_INPUTS + 1);

    state_t                   state;
    state_t                   state_nxt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  fin_sum;
    logic signed [PROD_W-1:0] bias_r;
    logic        [CNT_W-1:0]  cnt;
    logic                     sat_flag;
    logic                     len_err;
    logic                     accept;
    logic                     at_limit;
    logic        [OUT_W-1:0]  act;
    sat_res_t                 accum_res;
    sat_res_t                 fin_res;

    // Ready is masked by rst so the block never advertises space while reset
    // is being held, even though the state register already reads IDLE.
    assign prod_ready = !rst && (state == IDLE || state == ACCUM);
    assign accept     = prod_valid && prod_ready;
    assign at_limit   = (cnt + CNT_W'(1)) == CNT_W'(N_INPUTS);

    assign prod_ext = ACC_W'(prod_data);
    assign bias_ext = ACC_W'(bias_r);

    always_comb begin
        accum_res = sat_add(64'(acc), 64'(prod_ext), ACC_W);
        fin_res   = sat_add(64'(acc), 64'(bias_ext), ACC_W);
    end

    assign acc_sum = ACC_W'(accum_res.sum);
    assign fin_sum = ACC_W'(fin_res.sum);

    relu_clip #(
        .ACC_W      (ACC_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_relu_clip (
        .sum (fin_sum),
        .act (act)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (prod_last || N_INPUTS == 1) ? FINISH : ACCUM;
                end
            end
            ACCUM: begin
                if (accept && (prod_last || at_limit)) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: state_nxt = OUTPUT;
            OUTPUT: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            bias_r      <= '0;
            sat_flag    <= 1'b0;
            len_err     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sat     <= 1'b0;
            out_len_err <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc      <= prod_ext;
                        bias_r   <= bias;
                        cnt      <= CNT_W'(1);
                        sat_flag <= 1'b0;
                        len_err  <= (N_INPUTS == 1) && !prod_last;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc      <= acc_sum;
                        cnt      <= cnt + CNT_W'(1);
                        sat_flag <= sat_flag | accum_res.sat;
                        if (!prod_last && at_limit) begin
                            len_err <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    out_data    <= act;
                    out_sat     <= sat_flag | fin_res.sat;
                    out_len_err <= len_err;
                    out_valid   <= 1'b1;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        sat_flag  <= 1'b0;
                        len_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_accumulator.sv
module tb_neuron_accumulator;

    typedef struct {
        int data;
        int sat;
        int len;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              prod_valid;
    logic signed [19:0] prod_data;
    logic              prod_last;
    logic              prod_ready;
    logic signed [19:0] bias;
    logic              out_valid;
    logic [9:0]        out_data;
    logic              out_sat;
    logic              out_len_err;
    logic              out_ready;

    logic              b_prod_valid;
    logic signed [19:0] b_prod_data;
    logic              b_prod_last;
    logic              b_prod_ready;
    logic signed [19:0] b_bias;
    logic              b_out_valid;
    logic [9:0]        b_out_data;
    logic              b_out_sat;
    logic              b_out_len_err;
    logic              b_out_ready;

    int n_tests = 0;
    int n_fail  = 0;
    int negcnt  = 0;
    int t_last  = -100;
    exp_t sb[$];
    logic signed [19:0] pv[64];

    logic       prev_valid = 1'b0;
    logic       hold_prev  = 1'b0;
    logic [9:0] held_data  = '0;
    logic       held_sat   = 1'b0;
    logic       held_len   = 1'b0;

    neuron_accumulator dut (
        .clk         (clk),
        .rst         (rst),
        .prod_valid  (prod_valid),
        .prod_data   (prod_data),
        .prod_last   (prod_last),
        .prod_ready  (prod_ready),
        .bias        (bias),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_sat     (out_sat),
        .out_len_err (out_len_err),
        .out_ready   (out_ready)
    );

    neuron_accumulator #(.ACC_W(21)) dut_narrow (
        .clk         (clk),
        .rst         (rst),
        .prod_valid  (b_prod_valid),
        .prod_data   (b_prod_data),
        .prod_last   (b_prod_last),
        .prod_ready  (b_prod_ready),
        .bias        (b_bias),
        .out_valid   (b_out_valid),
        .out_data    (b_out_data),
        .out_sat     (b_out_sat),
        .out_len_err (b_out_len_err),
        .out_ready   (b_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // Reference: 27-bit clamped accumulation, bias add, ReLU, >>>6, clip to 1023.
    function automatic exp_t model(input int n, input logic signed [19:0] b0);
        longint hi = (64'sd1 <<< 26) - 1;
        longint lo = -(64'sd1 <<< 26);
        longint a  = 0;
        exp_t   e;
        e.sat = 0;
        for (int i = 0; i < n; i++) begin
            a = a + longint'(pv[i]);
            if (a > hi) begin a = hi; e.sat = 1; end
            if (a < lo) begin a = lo; e.sat = 1; end
        end
        a = a + longint'(b0);
        if (a > hi) begin a = hi; e.sat = 1; end
        if (a < lo) begin a = lo; e.sat = 1; end
        if (a < 0) e.data = 0;
        else if ((a >>> 6) > 1023) e.data = 1023;
        else e.data = int'(a >>> 6);
        e.len = 0;
        return e;
    endfunction

    // Output monitor: latency, hold stability and scoreboard comparison.
    always @(negedge clk) begin
        negcnt++;
        if (!rst) begin
            if (out_valid && !prev_valid) check("latency", negcnt - t_last, 2);
            if (hold_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, held_data);
                check("hold_sat", out_sat, held_sat);
                check("hold_len", out_len_err, held_len);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", out_valid, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_sat", out_sat, e.sat);
                    check("out_len_err", out_len_err, e.len);
                end
            end
        end
        prev_valid = out_valid;
        hold_prev  = out_valid && !out_ready && !rst;
        held_data  = out_data;
        held_sat   = out_sat;
        held_len   = out_len_err;
    end

    task automatic send_beat(input logic signed [19:0] d, input logic last,
                             input logic signed [19:0] b);
        int guard;
        guard = 0;
        prod_valid = 1'b1;
        prod_data  = d;
        prod_last  = last;
        bias       = b;
        @(negedge clk);
        while (!prod_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!prod_ready) begin
            check("beat_timeout", 0, 1);
        end else begin
            @(posedge clk);
            #1;
            t_last = negcnt;
        end
    endtask

    // Sends pv[0..n-1]; later beats carry a random bias that must be ignored.
    task automatic run_neuron(input int n, input logic use_last, input logic signed [19:0] b0,
                              input int ed, input int es, input int el);
        exp_t e;
        logic signed [19:0] rb;
        e.data = ed;
        e.sat  = es;
        e.len  = el;
        sb.push_back(e);
        for (int i = 0; i < n; i++) begin
            rb = 20'($urandom);
            send_beat(pv[i], use_last && (i == n - 1), (i == 0) ? b0 : rb);
        end
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    task automatic wait_out_valid();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!out_valid) check("out_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        int   guard;
        logic signed [19:0] b0;

        rst = 1'b1;
        prod_valid = 1'b0; prod_data = '0; prod_last = 1'b0; bias = '0; out_ready = 1'b1;
        b_prod_valid = 1'b0; b_prod_data = '0; b_prod_last = 1'b0; b_bias = '0; b_out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_prod_ready", prod_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_out_len_err", out_len_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", prod_ready, 1);
        @(posedge clk); #1;

        // Basic dot product with bias
        pv[0] = 20'sd1000; pv[1] = 20'sd2000; pv[2] = -20'sd500;
        run_neuron(3, 1'b1, 20'sd100, 40, 0, 0);

        // Negative sum: ReLU to zero
        pv[0] = -20'sd3000;
        run_neuron(1, 1'b1, 20'sd0, 0, 0, 0);

        // Clip to full scale
        pv[0] = 20'sd100000; pv[1] = 20'sd100000;
        run_neuron(2, 1'b1, 20'sd0, 1023, 0, 0);

        // Forced termination at 64 beats, consumer stalls for 5 cycles
        wait_out_valid();
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) pv[i] = 20'sd64;
        run_neuron(64, 1'b0, 20'sd0, 64, 0, 1);
        wait_out_valid();
        @(posedge clk); #1;
        prod_valid = 1'b1; prod_data = 20'sd7; prod_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_prod_ready", prod_ready, 0);
            @(posedge clk); #1;
        end
        prod_valid = 1'b0; prod_last = 1'b0;
        out_ready = 1'b1;

        // Abort a neuron with reset mid-accumulation
        for (int i = 0; i < 3; i++) send_beat(20'sd640, 1'b0, 20'sd0);
        prod_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort_prod_ready", prod_ready, 0);
        check("abort_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        pv[0] = 20'sd640;
        run_neuron(1, 1'b1, 20'sd0, 10, 0, 0);

        // Back-to-back random neurons
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) pv[i] = 20'($urandom);
            b0 = 20'($urandom);
            e = model(n, b0);
            run_neuron(n, 1'b1, b0, e.data, e.sat, e.len);
        end

        guard = 0;
        while ((sb.size() != 0 || out_valid) && guard < 300) begin
            @(posedge clk);
            guard++;
        end
        check("drain", sb.size(), 0);

        // Narrow accumulator: 3 x 500000 exceeds 2^20-1 and must clamp
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            b_prod_valid = 1'b1;
            b_prod_data  = 20'sd500000;
            b_prod_last  = (i == 2);
            b_bias       = 20'sd0;
            guard = 0;
            @(negedge clk);
            while (!b_prod_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            @(posedge clk); #1;
        end
        b_prod_valid = 1'b0; b_prod_last = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!b_out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("narrow_valid", b_out_valid, 1);
        check("narrow_data", b_out_data, 1023);
        check("narrow_sat", b_out_sat, 1);
        check("narrow_len_err", b_out_len_err, 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
